mean_window: RTL and testbench

Parametrised running-average stage for the computing cascade, the successor to the fixed single-mode mean. Averages a power-of-two number of valid samples, in either block mode (one result per N samples) or sliding mode (one result per sample after warm-up). Supports signed or unsigned data, optional round-half-up, and a synchronous clear. Sits between the sample-producing stage and the fft input, on the same valid-only (no back-pressure) stream.

---
 rtl/mean_pkg.sv | 21 ++
 rtl/mean_window_if.sv | 31 +++
 rtl/mean_ring_buf.sv | 46 ++++
 rtl/mean_window.sv | 136 +++++++++++++
 tb/tb_mean_window.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mean_pkg.sv
// mean_pkg: shared constants, state type and width helper for the mean_window
// running-average stage.
//   MEAN_BLOCK / MEAN_SLIDE : values of the MODE parameter
//   mean_state_e            : sliding-mode warm-up state (ST_FILL, ST_RUN)
//   acc_width()             : accumulator width for a given sample width and window size
package mean_pkg;

    localparam int MEAN_BLOCK = 0;
    localparam int MEAN_SLIDE = 1;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } mean_state_e;

    // Sum of 2^log2_n samples of 'width' bits needs log2_n extra bits.
    function automatic int acc_width(input int width, input int log2_n);
        return width + log2_n;
    endfunction

endpackage

// File: rtl/mean_window_if.sv
// mean_window_if: valid-only sample stream into and result stream out of
// mean_window (no back-pressure).
//   i_vld / i_data : input sample strobe and value
//   i_clr          : synchronous clear of the window state
//   o_vld / o_data : one-cycle result strobe and held mean value
// master = sample producer / result consumer, slave = mean_window.
interface mean_window_if #(
    parameter int WIDTH = 32
);
    logic             i_vld;
    logic [WIDTH-1:0] i_data;
    logic             i_clr;
    logic             o_vld;
    logic [WIDTH-1:0] o_data;

    modport master (
        output i_vld,
        output i_data,
        output i_clr,
        input  o_vld,
        input  o_data
    );

    modport slave (
        input  i_vld,
        input  i_data,
        input  i_clr,
        output o_vld,
        output o_data
    );
endinterface

// File: rtl/mean_ring_buf.sv
// mean_ring_buf: N x WIDTH circular buffer holding the last N samples of the
// sliding window.
//   clk, rstn : clock, asynchronous active-low reset (buffer and pointer to 0)
//   clr       : synchronous clear (buffer and pointer to 0), wins over adv
//   adv       : store wdata at the write pointer and advance it
//   oldest    : entry at the write pointer, i.e. the sample leaving the window
module mean_ring_buf #(
    parameter int WIDTH  = 32,
    parameter int LOG2_N = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             adv,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] oldest
);
    localparam int N = 1 << LOG2_N;

    logic [WIDTH-1:0]  mem_r [N];
    logic [LOG2_N-1:0] wp_r;

    // The slot about to be overwritten holds the sample from N writes ago.
    assign oldest = mem_r[wp_r];

    // Buffer storage and write pointer; pointer wraps naturally at N.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_r <= '0;
            for (int i = 0; i < N; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clr) begin
            wp_r <= '0;
            for (int i = 0; i < N; i++) begin
                mem_r[i] <= '0;
            end
        end else if (adv) begin
            mem_r[wp_r] <= wdata;
            wp_r        <= wp_r + LOG2_N'(1);
        end else begin
            wp_r <= wp_r;
        end
    end

endmodule

// File: rtl/mean_window.sv
// mean_window: running average over N = 2^LOG2_N valid samples.
//   MODE=MEAN_BLOCK : one result per N samples, windows never overlap
//   MODE=MEAN_SLIDE : one result per sample once N samples have been seen
//   SIG   : 1 signed two's-complement data, 0 unsigned
//   ROUND : 1 round half up, 0 floor
// Ports:
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : mean_window_if slave (i_vld, i_data, i_clr in; o_vld, o_data out)
// Results are registered: one cycle after the completing sample.
module mean_window
    import mean_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LOG2_N = 2,
    parameter int SIG    = 1,
    parameter int MODE   = 0,
    parameter int ROUND  = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    mean_window_if.slave         bus
);
    localparam int                AW       = acc_width(WIDTH, LOG2_N);
    localparam int                N        = 1 << LOG2_N;
    localparam logic [LOG2_N-1:0] CNT_LAST = LOG2_N'(N - 1);
    localparam logic [AW:0]       RND_ADD  = (ROUND != 0) ? (AW+1)'(2 ** (LOG2_N - 1)) : (AW+1)'(0);

    logic [AW-1:0]     acc_r;
    logic [LOG2_N-1:0] cnt_r;
    mean_state_e       state_r;
    logic              o_vld_r;
    logic [WIDTH-1:0]  o_data_r;

    logic [WIDTH-1:0]  old_s;
    logic [AW-1:0]     acc_nxt_s;
    logic [AW:0]       sum_rnd_s;
    logic [AW:0]       shifted_s;
    logic [WIDTH-1:0]  mean_s;

    // Widen a sample to accumulator width according to its signedness.
    function automatic logic [AW-1:0] ext(input logic [WIDTH-1:0] v);
        logic fill;
        fill = (SIG != 0) ? v[WIDTH-1] : 1'b0;
        return {{LOG2_N{fill}}, v};
    endfunction

    generate
        if (MODE == MEAN_SLIDE) begin : g_ring
            mean_ring_buf #(
                .WIDTH  (WIDTH),
                .LOG2_N (LOG2_N)
            ) u_ring (
                .clk    (clk),
                .rstn   (rstn),
                .clr    (bus.i_clr),
                .adv    (bus.i_vld),
                .wdata  (bus.i_data),
                .oldest (old_s)
            );
        end else begin : g_no_ring
            // Block mode never subtracts: the accumulator restarts each window.
            assign old_s = '0;
        end
    endgenerate

    // Next accumulator value and its rounded, shifted mean.
    always_comb begin
        acc_nxt_s = acc_r + ext(bus.i_data) - ext(old_s);
        // One extra bit keeps the rounding addend from overflowing.
        sum_rnd_s = {((SIG != 0) ? acc_nxt_s[AW-1] : 1'b0), acc_nxt_s} + RND_ADD;
        if (SIG != 0) begin
            shifted_s = $signed(sum_rnd_s) >>> LOG2_N;
        end else begin
            shifted_s = sum_rnd_s >> LOG2_N;
        end
        // Mean of in-range samples is in range, so dropping the top bits is lossless.
        mean_s = shifted_s[WIDTH-1:0];
    end

    // Accumulator, sample counter, warm-up FSM and registered result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_r    <= '0;
            cnt_r    <= '0;
            state_r  <= ST_FILL;
            o_vld_r  <= 1'b0;
            o_data_r <= '0;
        end else if (bus.i_clr) begin
            // Clear beats a same-cycle sample, which is dropped.
            acc_r    <= '0;
            cnt_r    <= '0;
            state_r  <= ST_FILL;
            o_vld_r  <= 1'b0;
        end else if (bus.i_vld) begin
            cnt_r <= cnt_r + LOG2_N'(1);
            if (MODE == MEAN_BLOCK) begin
                if (cnt_r == CNT_LAST) begin
                    acc_r    <= '0;
                    o_vld_r  <= 1'b1;
                    o_data_r <= mean_s;
                end else begin
                    acc_r    <= acc_nxt_s;
                    o_vld_r  <= 1'b0;
                end
            end else begin
                acc_r <= acc_nxt_s;
                case (state_r)
                    ST_FILL: begin
                        if (cnt_r == CNT_LAST) begin
                            state_r  <= ST_RUN;
                            o_vld_r  <= 1'b1;
                            o_data_r <= mean_s;
                        end else begin
                            o_vld_r  <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        o_vld_r  <= 1'b1;
                        o_data_r <= mean_s;
                    end
                    default: begin
                        state_r  <= ST_FILL;
                        o_vld_r  <= 1'b0;
                    end
                endcase
            end
        end else begin
            o_vld_r <= 1'b0;
        end
    end

    assign bus.o_vld  = o_vld_r;
    assign bus.o_data = o_data_r;

endmodule

// File: tb/tb_mean_window.sv
// tb_mean_window: drives one shared sample stream into six mean_window
// configurations and checks each against a window-of-history reference model,
// plus literal expectations for the documented scenarios.
module tb_mean_window;

    localparam int NCFG = 6;
    localparam int C_L2  [NCFG] = '{2, 2, 2, 2, 2, 3};
    localparam int C_SIG [NCFG] = '{1, 1, 1, 0, 1, 0};
    localparam int C_MODE[NCFG] = '{0, 0, 1, 0, 1, 1};
    localparam int C_RND [NCFG] = '{0, 1, 0, 0, 1, 1};

    logic        clk;
    logic        rstn;
    logic        i_vld;
    logic [31:0] i_data;
    logic        i_clr;

    logic        o_vld_a  [NCFG];
    logic [31:0] o_data_a [NCFG];

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        mean_window_if #(.WIDTH(32)) bus ();
        assign bus.i_vld    = i_vld;
        assign bus.i_data   = i_data;
        assign bus.i_clr    = i_clr;
        assign o_vld_a[g]   = bus.o_vld;
        assign o_data_a[g]  = bus.o_data;
        mean_window #(
            .WIDTH  (32),
            .LOG2_N (C_L2[g]),
            .SIG    (C_SIG[g]),
            .MODE   (C_MODE[g]),
            .ROUND  (C_RND[g])
        ) u_dut (
            .clk  (clk),
            .rstn (rstn),
            .bus  (bus)
        );
    end

    // ---------------- reference model ----------------
    logic [31:0] hist[$];
    int          nsamp;
    logic        exp_vld  [NCFG];
    logic [31:0] exp_data [NCFG];

    function automatic logic [31:0] ref_mean(input int c);
        longint s;
        int     n;
        logic [31:0] x;
        s = 0;
        n = 1 << C_L2[c];
        for (int i = 0; i < n; i++) begin
            x = hist[hist.size() - 1 - i];
            if (C_SIG[c] != 0) s += longint'($signed(x));
            else               s += longint'({32'd0, x});
        end
        if (C_RND[c] != 0) s += longint'(1) << (C_L2[c] - 1);
        s = s >>> C_L2[c];
        return s[31:0];
    endfunction

    initial begin
        nsamp = 0;
        for (int c = 0; c < NCFG; c++) begin
            exp_vld[c]  = 1'b0;
            exp_data[c] = 32'd0;
        end
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                hist.delete();
                nsamp = 0;
                for (int c = 0; c < NCFG; c++) begin
                    exp_vld[c]  = 1'b0;
                    exp_data[c] = 32'd0;
                end
            end else if (i_clr) begin
                hist.delete();
                nsamp = 0;
                for (int c = 0; c < NCFG; c++) exp_vld[c] = 1'b0;
            end else if (i_vld) begin
                hist.push_back(i_data);
                if (hist.size() > 8) void'(hist.pop_front());
                nsamp++;
                for (int c = 0; c < NCFG; c++) begin
                    int  n;
                    logic fire;
                    n    = 1 << C_L2[c];
                    fire = (C_MODE[c] == 0) ? ((nsamp % n) == 0) : (nsamp >= n);
                    exp_vld[c] = fire;
                    if (fire) exp_data[c] = ref_mean(c);
                end
            end else begin
                for (int c = 0; c < NCFG; c++) exp_vld[c] = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NCFG; c++) begin
                total++;
                if (o_vld_a[c] !== exp_vld[c] || o_data_a[c] !== exp_data[c]) begin
                    bad++;
                    $display("FAIL cmp cfg%0d t=%0t: got vld=%0b data=%h, want vld=%0b data=%h",
                             c, $time, o_vld_a[c], o_data_a[c], exp_vld[c], exp_data[c]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] d, input logic c);
        @(negedge clk);
        i_vld  = v;
        i_data = d;
        i_clr  = c;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rstn   = 1'b0;
        i_vld  = 1'b0;
        i_data = 32'd0;
        i_clr  = 1'b0;
        repeat (3) @(negedge clk);
        for (int c = 0; c < NCFG; c++) begin
            chk("reset_vld",  {31'd0, o_vld_a[c]}, 32'd0);
            chk("reset_data", o_data_a[c], 32'd0);
        end
        rstn = 1'b1;

        // Block floor/round and sliding on 1,-2,3,4,8,0, gap, 4.
        drv(1'b0, 32'd0, 1'b1);
        drv(1'b1, 32'd1, 1'b0);
        drv(1'b1, 32'hFFFF_FFFE, 1'b0);
        drv(1'b1, 32'd3, 1'b0);
        drv(1'b1, 32'd4, 1'b0);
        settle();
        chk("blk_floor_vld",  {31'd0, o_vld_a[0]}, 32'd1);
        chk("blk_floor",      o_data_a[0], 32'd1);
        chk("blk_floor_model", exp_data[0], 32'd1);
        chk("blk_round",      o_data_a[1], 32'd2);
        chk("slide_first",    o_data_a[2], 32'd1);
        drv(1'b1, 32'd8, 1'b0);
        settle();
        chk("slide_13",       o_data_a[2], 32'd3);
        drv(1'b1, 32'd0, 1'b0);
        settle();
        chk("slide_15",       o_data_a[2], 32'd3);
        drv(1'b0, 32'hDEAD_BEEF, 1'b0);
        settle();
        chk("gap_vld",        {31'd0, o_vld_a[2]}, 32'd0);
        chk("gap_hold",       o_data_a[2], 32'd3);
        repeat (4) drv(1'b0, 32'hDEAD_BEEF, 1'b0);
        drv(1'b1, 32'd4, 1'b0);
        settle();
        chk("slide_after_gap",       o_data_a[2], 32'd4);
        chk("slide_after_gap_model", exp_data[2], 32'd4);

        // Negative rounding: -1,-1,-1,-2.
        drv(1'b0, 32'd0, 1'b1);
        drv(1'b1, 32'hFFFF_FFFF, 1'b0);
        drv(1'b1, 32'hFFFF_FFFF, 1'b0);
        drv(1'b1, 32'hFFFF_FFFF, 1'b0);
        drv(1'b1, 32'hFFFF_FFFE, 1'b0);
        settle();
        chk("neg_floor",       o_data_a[0], 32'hFFFF_FFFE);
        chk("neg_round",       o_data_a[1], 32'hFFFF_FFFF);
        chk("neg_round_model", exp_data[1], 32'hFFFF_FFFF);

        // Unsigned extremes.
        drv(1'b0, 32'd0, 1'b1);
        repeat (4) drv(1'b1, 32'hFFFF_FFFF, 1'b0);
        settle();
        chk("unsigned_max", o_data_a[3], 32'hFFFF_FFFF);

        // Clear priority over a same-cycle sample.
        drv(1'b0, 32'd0, 1'b1);
        drv(1'b1, 32'd1, 1'b0);
        drv(1'b1, 32'd2, 1'b0);
        drv(1'b1, 32'd3, 1'b0);
        drv(1'b1, 32'd9, 1'b1);
        drv(1'b1, 32'd4, 1'b0);
        drv(1'b1, 32'd4, 1'b0);
        drv(1'b1, 32'd4, 1'b0);
        settle();
        chk("clr_no_early", {31'd0, o_vld_a[2]}, 32'd0);
        drv(1'b1, 32'd4, 1'b0);
        settle();
        chk("clr_first_vld", {31'd0, o_vld_a[2]}, 32'd1);
        chk("clr_first",     o_data_a[2], 32'd4);
        chk("clr_first_rnd", o_data_a[4], 32'd4);

        // Asynchronous reset mid-window.
        drv(1'b0, 32'd0, 1'b1);
        drv(1'b1, 32'd5, 1'b0);
        drv(1'b1, 32'd5, 1'b0);
        drv(1'b0, 32'd0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_vld",  {31'd0, o_vld_a[0]}, 32'd0);
        chk("async_rst_data", o_data_a[0], 32'd0);
        #1 rstn = 1'b1;
        repeat (4) drv(1'b1, 32'd2, 1'b0);
        settle();
        chk("post_rst_vld", {31'd0, o_vld_a[0]}, 32'd1);
        chk("post_rst",     o_data_a[0], 32'd2);

        // Randomized traffic with clears and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] d;
            int          sel;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       d = 32'd0;
                1:       d = 32'hFFFF_FFFF;
                2:       d = 32'h7FFF_FFFF;
                3:       d = 32'h8000_0000;
                default: d = $urandom;
            endcase
            drv(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 99) < 3));
            if ($urandom_range(0, 499) == 0) begin
                #2 rstn = 1'b0;
                #2 rstn = 1'b1;
            end
        end
        repeat (3) drv(1'b0, 32'd0, 1'b0);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
